// File: rtl/fp_operand_loader.sv
// fp_operand_loader: assembles two IEEE-754 single-precision operands for an
// FP adder from eight byte entries made on slide switches, one byte per
// debounced push-button press, MSB first (op_a then op_b).
module fp_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic [7:0]  sw,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  output logic [3:0]  byte_idx,
  output logic        loaded
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    DONE
  } state_t;

  logic          btn_s1, btn_s2;
  logic [7:0]    sw_s1, sw_s2;
  logic [CW-1:0] db_cnt;
  logic          db_level;
  logic          db_level_q;
  logic          press;
  state_t        state_q, state_d;

  // Two-flop synchronizers for the asynchronous button and switch inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: accept a level change only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_s2 != db_level) begin
      if (db_cnt == CNT_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered one-cycle press pulse on the debounced rising edge only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level_q <= 1'b0;
      press      <= 1'b0;
    end else begin
      db_level_q <= db_level;
      press      <= db_level & ~db_level_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: advance on the press that completes each operand
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_A:  if (press && byte_idx == 4'd3) state_d = LOAD_B;
      LOAD_B:  if (press && byte_idx == 4'd7) state_d = DONE;
      DONE:    if (press) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
  end

  // Operand datapath: write the synchronized switch byte into the slot
  // selected by byte_idx on each press; a press in DONE starts a new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      byte_idx <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (press) begin
        case (state_q)
          LOAD_A: begin
            case (byte_idx[1:0])
              2'd0: op_a[31:24] <= sw_s2;
              2'd1: op_a[23:16] <= sw_s2;
              2'd2: op_a[15:8]  <= sw_s2;
              default: op_a[7:0] <= sw_s2;
            endcase
            byte_idx <= byte_idx + 4'd1;
          end
          LOAD_B: begin
            case (byte_idx[1:0])
              2'd0: op_b[31:24] <= sw_s2;
              2'd1: op_b[23:16] <= sw_s2;
              2'd2: op_b[15:8]  <= sw_s2;
              default: op_b[7:0] <= sw_s2;
            endcase
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == 4'd7) op_valid <= 1'b1;
          end
          DONE: begin
            op_a     <= {sw_s2, 24'h000000};
            op_b     <= '0;
            byte_idx <= 4'd1;
          end
          default: begin
            op_a     <= '0;
            op_b     <= '0;
            byte_idx <= '0;
          end
        endcase
      end
    end
  end

  assign loaded = (state_q == DONE);

endmodule

// File: tb/tb_fp_operand_loader.sv
// Testbench for fp_operand_loader: scenario tasks with inline checks plus a
// scoreboard of expected {op_a, op_b} pairs popped on each op_valid pulse.
module tb_fp_operand_loader;

  localparam int unsigned DB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic [7:0]  sw;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic [3:0]  byte_idx;
  logic        loaded;

  int assertions = 0;
  int failures   = 0;
  int valid_cnt  = 0;
  logic [63:0] exp_q[$];

  fp_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .sw       (sw),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .byte_idx (byte_idx),
    .loaded   (loaded)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: each op_valid cycle must match the next expected pair
  always @(negedge clk) begin
    if (!rst && op_valid) begin
      logic [63:0] exp;
      valid_cnt++;
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid: got a=%h b=%h, required no op_valid", op_a, op_b);
      end else begin
        exp = exp_q.pop_front();
        if ({op_a, op_b, byte_idx, loaded} !== {exp, 4'd8, 1'b1}) begin
          failures++;
          $display("FAIL sb_operands: got a=%h b=%h idx=%0d ld=%b, required a=%h b=%h idx=8 ld=1",
                   op_a, op_b, byte_idx, loaded, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic press(input logic [7:0] val);
    @(negedge clk);
    sw  = val;
    btn = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    btn = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load8(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] v;
    v = {a, b};
    exp_q.push_back(v);
    for (int i = 7; i >= 0; i--) press(v[i*8 +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 1'b0; sw = 8'hff;
    repeat (3) @(negedge clk);
    assertions++;
    if ({op_a, op_b, op_valid, byte_idx, loaded} !== 69'd0) begin
      failures++;
      $display("FAIL reset_outputs: got a=%h b=%h v=%b idx=%0d ld=%b, required all 0",
               op_a, op_b, op_valid, byte_idx, loaded);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_load();
    int v0;
    v0 = valid_cnt;
    load8(32'h6b64b235, 32'h6ac49214);
    @(negedge clk);
    assertions++;
    if (valid_cnt - v0 !== 1) begin
      failures++;
      $display("FAIL clean_valid_pulses: got %0d op_valid cycles, required 1", valid_cnt - v0);
    end
    assertions++;
    if ({op_a, op_b, byte_idx, loaded} !== {32'h6b64b235, 32'h6ac49214, 4'd8, 1'b1}) begin
      failures++;
      $display("FAIL clean_done_hold: got a=%h b=%h idx=%0d ld=%b, required 6b64b235 6ac49214 8 1",
               op_a, op_b, byte_idx, loaded);
    end
  endtask

  task automatic test_done_reload();
    int v0;
    v0 = valid_cnt;
    press(8'h3f);
    assertions++;
    if ({op_a, op_b, byte_idx, loaded} !== {32'h3f000000, 32'h0, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL done_reload: got a=%h b=%h idx=%0d ld=%b, required 3f000000 0 1 0",
               op_a, op_b, byte_idx, loaded);
    end
    assertions++;
    if (valid_cnt !== v0) begin
      failures++;
      $display("FAIL done_reload_valid: got %0d op_valid cycles, required 0", valid_cnt - v0);
    end
  endtask

  task automatic test_sw_noise();
    logic [72:0] snap;
    logic [72:0] now;
    @(negedge clk);
    snap = {op_a, op_b, op_valid, byte_idx, loaded};
    for (int i = 0; i < 200; i++) begin
      sw = ~sw;
      @(negedge clk);
      now = {op_a, op_b, op_valid, byte_idx, loaded};
      assertions++;
      if (now !== snap) begin
        failures++;
        $display("FAIL sw_noise cycle %0d: got %h, required %h", i, now, snap);
      end
    end
  endtask

  task automatic test_long_hold();
    logic [3:0] idx0;
    idx0 = byte_idx;
    @(negedge clk);
    sw = 8'h64; btn = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    assertions++;
    if (byte_idx !== idx0 + 4'd1) begin
      failures++;
      $display("FAIL long_hold_idx: got %0d, required %0d", byte_idx, idx0 + 4'd1);
    end
    btn = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  // Bounce then held rise: the byte lands on the (DB+4)th edge counting the
  // first edge that samples btn high as edge 1 (event pulse after DB+2 more).
  task automatic test_debounce_timing();
    int first_n;
    do_reset();
    repeat (4) @(negedge clk);
    sw = 8'hc4;
    for (int r = 0; r < 2; r++) begin
      btn = 1'b1; repeat (5) @(negedge clk);
      btn = 1'b0; repeat (5) @(negedge clk);
    end
    btn = 1'b1;
    first_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (byte_idx !== 4'd0 && first_n == 0) first_n = n;
    end
    assertions++;
    if (first_n !== int'(DB + 4)) begin
      failures++;
      $display("FAIL debounce_timing: byte accepted at edge %0d, required %0d", first_n, DB + 4);
    end
    assertions++;
    if ({byte_idx, op_a} !== {4'd1, 32'hc4000000}) begin
      failures++;
      $display("FAIL debounce_single: got idx=%0d a=%h, required 1 c4000000", byte_idx, op_a);
    end
    @(negedge clk);
    btn = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    repeat (4) @(negedge clk);
    press(8'h6b); press(8'h64); press(8'hb2);
    assertions++;
    if ({op_a, byte_idx} !== {32'h6b64b200, 4'd3}) begin
      failures++;
      $display("FAIL mid_partial: got a=%h idx=%0d, required 6b64b200 3", op_a, byte_idx);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    assertions++;
    if ({op_a, op_b, op_valid, byte_idx, loaded} !== 69'd0) begin
      failures++;
      $display("FAIL mid_async_reset: got a=%h b=%h v=%b idx=%0d ld=%b, required all 0",
               op_a, op_b, op_valid, byte_idx, loaded);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    load8(32'h40490fdb, 32'hbf800000);
    assertions++;
    if ({op_a, op_b, loaded} !== {32'h40490fdb, 32'hbf800000, 1'b1}) begin
      failures++;
      $display("FAIL mid_reload: got a=%h b=%h ld=%b, required 40490fdb bf800000 1",
               op_a, op_b, loaded);
    end
  endtask

  task automatic test_btn_held_through_reset();
    @(negedge clk);
    rst = 1'b1; sw = 8'h92; btn = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    assertions++;
    if ({byte_idx, op_a} !== {4'd1, 32'h92000000}) begin
      failures++;
      $display("FAIL held_rst_event: got idx=%0d a=%h, required 1 92000000", byte_idx, op_a);
    end
    repeat (60) @(negedge clk);
    assertions++;
    if (byte_idx !== 4'd1) begin
      failures++;
      $display("FAIL held_rst_second: got idx=%0d, required 1", byte_idx);
    end
    btn = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b0; sw = '0;
    test_reset();
    test_clean_load();
    test_sw_noise();
    test_done_reload();
    test_long_hold();
    test_debounce_timing();
    test_reset_mid_load();
    test_btn_held_through_reset();
    repeat (5) @(negedge clk);
    assertions++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending loads, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
